// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_mul_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> HI/LO unit signal bundle; master is the pipeline side.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic              op_valid;
  muldiv_op_t        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              ex_stall;
  logic              flush;
  logic              stall_req;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, ex_stall, flush,
    input  stall_req, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, ex_stall, flush,
    output stall_req, hi, lo
  );

endinterface

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// quotient/remainder show the result of the step taken this cycle; done marks the final step.
module muldiv_divider
  import muldiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [2*DATA_W-1:0]     rq;
  logic [2*DATA_W-1:0]     rq_nxt;
  logic [DATA_W-1:0]       dvs;
  logic [5:0]              cnt;
  logic [DATA_W:0]         rem_sh;
  logic signed [DATA_W+1:0] diff;

  // Shifted partial remainder needs one extra bit before the trial subtract.
  always_comb begin
    rem_sh = rq[2*DATA_W-1:DATA_W-1];
    diff   = $signed({1'b0, rem_sh}) - $signed({2'b00, dvs});
    if (diff[DATA_W+1]) begin
      rq_nxt = {rem_sh[DATA_W-1:0], rq[DATA_W-2:0], 1'b0};
    end else begin
      rq_nxt = {diff[DATA_W-1:0], rq[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq  <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rq  <= {{DATA_W{1'b0}}, dividend};
      dvs <= divisor;
      cnt <= 6'(DIV_STEPS);
    end else if (cnt != '0) begin
      rq  <= rq_nxt;
      cnt <= cnt - 6'd1;
    end
  end

  assign busy      = (cnt != '0);
  assign done      = (cnt == 6'd1);
  assign quotient  = rq_nxt[DATA_W-1:0];
  assign remainder = rq_nxt[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO execution unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns HI and LO,
// and holds the issuing instruction in EX via stall_req until the result is written.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic [5:0]          count;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                mul_signed_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                issue_mul;
  logic                issue_div;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;

  logic                stall;
  logic                hi_we;
  logic                lo_we;
  logic [DATA_W-1:0]   hi_d;
  logic [DATA_W-1:0]   lo_d;

  logic                div_busy;
  logic                div_done;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   div_r;

  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [2*DATA_W-1:0]        product;

  function automatic logic [DATA_W-1:0] set_sign(input logic [DATA_W-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign issue_mul = bus.op_valid && !bus.flush && is_mul_op(bus.op);
  assign issue_div = bus.op_valid && !bus.flush && is_div_op(bus.op);

  // Only DIV treats operands as signed; magnitude of 0x80000000 is 2^31 as unsigned.
  assign a_neg = (bus.op == OP_DIV) && bus.src_a[DATA_W-1];
  assign b_neg = (bus.op == OP_DIV) && bus.src_b[DATA_W-1];
  assign abs_a = set_sign(bus.src_a, a_neg);
  assign abs_b = set_sign(bus.src_b, b_neg);

  muldiv_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     ((state == ST_IDLE) && issue_div),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign prod_s  = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) * $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
  assign prod_u  = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign product = mul_signed_q ? $unsigned(prod_s) : prod_u;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_mul)      state_nxt = ST_MUL;
          else if (issue_div) state_nxt = ST_DIV;
        end
        ST_MUL:  if (count == '0) state_nxt = ST_DONE;
        ST_DIV: begin
          if (div_done)       state_nxt = ST_DONE;
          else if (!div_busy) state_nxt = ST_IDLE;
        end
        ST_DONE: if (!bus.ex_stall) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Any flush suppresses the HI/LO write, including a final step or MTHI/MTLO.
  always_comb begin
    stall = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_d  = '0;
    lo_d  = '0;
    case (state)
      ST_IDLE: begin
        stall = issue_mul || issue_div;
        if (bus.op_valid && !bus.flush) begin
          if (bus.op == OP_MTHI) begin
            hi_we = 1'b1;
            hi_d  = bus.src_a;
          end
          if (bus.op == OP_MTLO) begin
            lo_we = 1'b1;
            lo_d  = bus.src_a;
          end
        end
      end
      ST_MUL: begin
        stall = 1'b1;
        if ((count == '0) && !bus.flush) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = product[2*DATA_W-1:DATA_W];
          lo_d  = product[DATA_W-1:0];
        end
      end
      ST_DIV: begin
        stall = 1'b1;
        if (div_done && !bus.flush) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = set_sign(div_r, r_neg_q);
          lo_d  = set_sign(div_q, q_neg_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
      if ((state == ST_IDLE) && (issue_mul || issue_div)) begin
        count        <= issue_mul ? 6'(MUL_LATENCY - 1) : 6'(DIV_STEPS - 1);
        a_q          <= issue_mul ? bus.src_a : abs_a;
        b_q          <= issue_mul ? bus.src_b : abs_b;
        mul_signed_q <= (bus.op == OP_MULT);
        q_neg_q      <= a_neg ^ b_neg;
        r_neg_q      <= a_neg;
      end else if (((state == ST_MUL) || (state == ST_DIV)) && (count != '0)) begin
        count <= count - 6'd1;
      end
    end
  end

  assign bus.stall_req = stall;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int MUL_LAT = 2;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall_len;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          run_len  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  // Architectural result of a mul/div op, from plain integer arithmetic.
  function automatic void model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint          ps;
    longint unsigned pu;
    h = '0;
    l = '0;
    case (op)
      OP_MULT:  begin ps = sa * sb; h = ps[63:32]; l = ps[31:0]; end
      OP_MULTU: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
      OP_DIVU: begin
        if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = 32'(ua / ub); h = 32'(ua % ub); end
      end
      OP_DIV: begin
        if (b == 0) begin l = (sa < 0) ? 32'h1 : 32'hFFFF_FFFF; h = a; end
        else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      default: ;
    endcase
  endfunction

  // Monitor: a completed stall run is one mul/div retirement.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run_len = 0;
    end else if (bus.stall_req) begin
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_op: stall ran %0d cycles, expected no operation in flight", run_len);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_hi"}, bus.hi, e.hi);
        check({e.name, "_lo"}, bus.lo, e.lo);
        check({e.name, "_stall_len"}, 32'(run_len), 32'(e.stall_len));
      end
      run_len = 0;
    end
  end

  task automatic drive(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
  endtask

  task automatic idle_bus();
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.stall_req || bus.ex_stall) && n < 100);
    if (bus.stall_req || bus.ex_stall) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, expected release", name, n);
    end
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic exec(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input string name);
    @(posedge clk);
    #1;
    if (is_mul_op(op) || is_div_op(op)) begin
      exp_q.push_back('{hi: eh, lo: el, stall_len: 1 + (is_mul_op(op) ? MUL_LAT : DIV_STEPS), name: name});
      m_hi = eh;
      m_lo = el;
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
    drive(op, a, b);
    wait_release(name);
    if (op == OP_MTHI || op == OP_MTLO) begin
      check({name, "_hi"}, bus.hi, m_hi);
      check({name, "_lo"}, bus.lo, m_lo);
    end
  endtask

  task automatic exec_rand(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    model(op, a, b, eh, el);
    exec(op, a, b, eh, el, "rand");
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    int          n;
    rst          = 1'b1;
    bus.ex_stall = 1'b0;
    bus.flush    = 1'b0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    idle_bus();
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_stall", 32'(bus.stall_req), 32'h0);

    exec(OP_MULT,  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, "mult_neg7x6");
    exec(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    exec(OP_DIVU,  32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, "divu_big_by2");
    exec(OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, "divu_by_zero");
    exec(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");

    // MTHI then MTLO on consecutive cycles
    @(posedge clk);
    #1;
    drive(OP_MTHI, 32'h1234_5678, 32'h0);
    @(negedge clk);
    check("mthi_stall", 32'(bus.stall_req), 32'h0);
    @(posedge clk);
    #1;
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_lo_kept", bus.lo, m_lo);
    drive(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    @(negedge clk);
    check("mtlo_stall", 32'(bus.stall_req), 32'h0);
    @(posedge clk);
    #1;
    idle_bus();
    check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // MTHI with flush in the same cycle
    @(posedge clk);
    #1;
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    idle_bus();
    check("mthi_flush_hi", bus.hi, m_hi);

    // Flush during the 10th DIV cycle
    @(posedge clk);
    #1;
    exp_q.push_back('{hi: m_hi, lo: m_lo, stall_len: 11, name: "div_flush"});
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("div_flush_idle_stall", 32'(bus.stall_req), 32'h0);
    check("div_flush_hi", bus.hi, m_hi);
    check("div_flush_lo", bus.lo, m_lo);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    idle_bus();

    // Flush on the final MUL step
    @(posedge clk);
    #1;
    exp_q.push_back('{hi: m_hi, lo: m_lo, stall_len: 1 + MUL_LAT, name: "mul_flush"});
    drive(OP_MULT, 32'd3, 32'd4);
    repeat (MUL_LAT) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    idle_bus();
    check("mul_flush_hi", bus.hi, m_hi);
    check("mul_flush_lo", bus.lo, m_lo);

    // DIV completes while EX is held for 4 cycles with op_valid kept high
    model(OP_DIV, 32'hFFFF_FC18, 32'd7, eh, el);
    @(posedge clk);
    #1;
    exp_q.push_back('{hi: eh, lo: el, stall_len: 1 + DIV_STEPS, name: "div_exstall"});
    m_hi = eh;
    m_lo = el;
    drive(OP_DIV, 32'hFFFF_FC18, 32'd7);
    bus.ex_stall = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stall_req && n < 100);
    check("div_exstall_done_stall", 32'(bus.stall_req), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("div_exstall_hold_stall", 32'(bus.stall_req), 32'h0);
      check("div_exstall_hold_hi", bus.hi, m_hi);
      check("div_exstall_hold_lo", bus.lo, m_lo);
    end
    bus.ex_stall = 1'b0;
    @(posedge clk);
    #1;
    idle_bus();
    exec(OP_MTHI, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, "mthi_after_done");

    for (int i = 0; i < 40; i++) begin
      exec_rand(muldiv_op_t'(3'($urandom_range(1, 6))), rnd_operand(), rnd_operand());
    end

    // Reset in the middle of a MULT
    @(posedge clk);
    #1;
    drive(OP_MULT, 32'd7, 32'd9);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bus();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_mult_hi", bus.hi, 32'h0);
    check("rst_mid_mult_lo", bus.lo, 32'h0);
    check("rst_mid_mult_stall", 32'(bus.stall_req), 32'h0);
    m_hi = '0;
    m_lo = '0;
    exec(OP_MTLO, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0, "mtlo_after_rst");
    exec_rand(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
